// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic-array sequencer.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        WB,
        DONE
    } ctrl_state_t;

    // Read latency, skew fill across both array edges, and the MAC pipeline.
    function automatic int drain_cycles(int size, int rd_lat, int pe_lat);
        return rd_lat + 2 * (size - 1) + pe_lat;
    endfunction

    // The shared counter must hold the largest terminal count of any state.
    function automatic int cnt_width(int size, int rd_lat, int pe_lat);
        int d;
        int m;
        d = drain_cycles(size, rd_lat, pe_lat);
        m = (d > size) ? d : size;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/systolic_ctrl_delay_line.sv
// Resettable fixed-depth delay line; DEPTH = 0 is a plain wire.
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q_o = d_i;
        end else begin : g_pipe
            logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign q_o = pipe_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for the SIZE x SIZE systolic matmul: clear, feed, drain, write back.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int SIZE   = 32,
    parameter int ADDR_W = $clog2(SIZE),
    parameter int RD_LAT = 1,
    parameter int PE_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              host_lock,
    output logic              acc_clr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              feed_valid,
    output logic              out_shift,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr
);

    localparam int DRAIN_CYC = drain_cycles(SIZE, RD_LAT, PE_LAT);
    localparam int CNT_W     = cnt_width(SIZE, RD_LAT, PE_LAT);
    localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(SIZE - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);

    ctrl_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              done_q, idle_q, lock_q, clr_q, rd_en_q, wb_q;
    logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ap_start) state_d = CLEAR;
            end
            CLEAR: begin
                state_d = FEED;
                cnt_d   = '0;
            end
            FEED: begin
                if (cnt_q == ROW_LAST) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = WB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WB: begin
                if (cnt_q == ROW_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so every output comes straight off a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            idle_q    <= 1'b1;
            lock_q    <= 1'b0;
            clr_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            wb_q      <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= (state_d == DONE);
            idle_q  <= (state_d == IDLE);
            lock_q  <= (state_d != IDLE);
            clr_q   <= (state_d == CLEAR);
            rd_en_q <= (state_d == FEED);
            wb_q    <= (state_d == WB);
            if (state_d == FEED) rd_addr_q <= ADDR_W'(cnt_d);
            if (state_d == WB)   wr_addr_q <= ADDR_W'(cnt_d);
        end
    end

    delay_line #(
        .WIDTH (1),
        .DEPTH (RD_LAT)
    ) u_feed_dly (
        .clk (clk),
        .rst (rst),
        .d_i (rd_en_q),
        .q_o (feed_valid)
    );

    assign ap_done   = done_q;
    assign ap_idle   = idle_q;
    assign host_lock = lock_q;
    assign acc_clr   = clr_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign out_shift = wb_q;
    assign o_wr_en   = wb_q;
    assign o_wr_addr = wr_addr_q;

endmodule
